// File: rtl/control_unit_if.sv
// Bundle between control_unit and the datapath side: instruction/zero flag in,
// control word and memory strobes out, plus the FSM state for observation.
interface control_unit_if;
   logic [31:0] INSTRUCTION;
   logic        ZERO;
   logic [31:0] CTRL;
   logic        READ;
   logic        WRITE;
   logic [2:0]  fsm_state;

   modport master (output INSTRUCTION, ZERO, input CTRL, READ, WRITE, fsm_state);
   modport slave  (input INSTRUCTION, ZERO, output CTRL, READ, WRITE, fsm_state);
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit: fixed FETCH->DECODE->EXE->MEM->WB sequence with an
// internal instruction latch; CTRL/READ/WRITE decode from state and latch only.
module control_unit #(
   parameter int         CTRL_WIDTH = 32,
   parameter logic [4:0] ALU_ADD    = 5'd1,
   parameter logic [4:0] ALU_SUB    = 5'd2,
   parameter logic [4:0] ALU_MUL    = 5'd3,
   parameter logic [4:0] ALU_SHR    = 5'd4,
   parameter logic [4:0] ALU_SHL    = 5'd5,
   parameter logic [4:0] ALU_AND    = 5'd6,
   parameter logic [4:0] ALU_OR     = 5'd7,
   parameter logic [4:0] ALU_NOR    = 5'd8,
   parameter logic [4:0] ALU_SLT    = 5'd9
) (
   input logic           CLK,
   input logic           RST,
   control_unit_if.slave bus
);
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   state_t                state, state_nxt;
   logic [31:0]           ir;
   logic [CTRL_WIDTH-1:0] ctrl, ex_bits;
   logic                  read, write;
   logic [4:0]            alu;
   logic wr_rd, wr_rt, is_lw, is_sw, is_push, is_pop, is_lui;
   logic is_beq, is_bne, is_jr, is_jump, is_jal;
   logic [5:0]            opcode, funct;
   logic                  ir_unused;

   assign opcode    = ir[31:26];
   assign funct     = ir[5:0];
   assign ir_unused = ^ir[25:6];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= FETCH;
         ir    <= '0;
      end else begin
         state <= state_nxt;
         if (state == FETCH) ir <= bus.INSTRUCTION;
      end
   end

   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH:   state_nxt = DECODE;
         DECODE:  state_nxt = EXE;
         EXE:     state_nxt = MEM;
         MEM:     state_nxt = WB;
         default: state_nxt = FETCH;
      endcase
   end

   // Instruction classification and the EXE-phase operand/ALU selects.
   always_comb begin
      ex_bits = '0;
      alu     = '0;
      wr_rd = 1'b0; wr_rt = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
      is_push = 1'b0; is_pop = 1'b0; is_lui = 1'b0; is_beq = 1'b0;
      is_bne = 1'b0; is_jr = 1'b0; is_jump = 1'b0; is_jal = 1'b0;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h20: begin ex_bits[20] = 1'b1; alu = ALU_ADD; wr_rd = 1'b1; end
               6'h22: begin ex_bits[20] = 1'b1; alu = ALU_SUB; wr_rd = 1'b1; end
               6'h2c: begin ex_bits[20] = 1'b1; alu = ALU_MUL; wr_rd = 1'b1; end
               6'h24: begin ex_bits[20] = 1'b1; alu = ALU_AND; wr_rd = 1'b1; end
               6'h25: begin ex_bits[20] = 1'b1; alu = ALU_OR;  wr_rd = 1'b1; end
               6'h27: begin ex_bits[20] = 1'b1; alu = ALU_NOR; wr_rd = 1'b1; end
               6'h2a: begin ex_bits[20] = 1'b1; alu = ALU_SLT; wr_rd = 1'b1; end
               6'h01: begin ex_bits[19] = 1'b1; ex_bits[17] = 1'b1; alu = ALU_SHL; wr_rd = 1'b1; end
               6'h02: begin ex_bits[19] = 1'b1; ex_bits[17] = 1'b1; alu = ALU_SHR; wr_rd = 1'b1; end
               6'h08: is_jr = 1'b1;
               default: ;
            endcase
         end
         6'h08: begin ex_bits[18] = 1'b1; alu = ALU_ADD; wr_rt = 1'b1; end
         6'h1d: begin ex_bits[18] = 1'b1; alu = ALU_MUL; wr_rt = 1'b1; end
         6'h0a: begin ex_bits[18] = 1'b1; alu = ALU_SLT; wr_rt = 1'b1; end
         6'h23: begin ex_bits[18] = 1'b1; alu = ALU_ADD; wr_rt = 1'b1; is_lw = 1'b1; end
         6'h2b: begin ex_bits[18] = 1'b1; alu = ALU_ADD; is_sw = 1'b1; end
         6'h0c: begin alu = ALU_AND; wr_rt = 1'b1; end
         6'h0d: begin alu = ALU_OR;  wr_rt = 1'b1; end
         6'h0f: begin wr_rt = 1'b1; is_lui = 1'b1; end
         6'h04: begin ex_bits[20] = 1'b1; alu = ALU_SUB; is_beq = 1'b1; end
         6'h05: begin ex_bits[20] = 1'b1; alu = ALU_SUB; is_bne = 1'b1; end
         6'h1b: begin ex_bits[16] = 1'b1; ex_bits[19] = 1'b1; alu = ALU_SUB; is_push = 1'b1; end
         6'h1c: begin ex_bits[16] = 1'b1; ex_bits[19] = 1'b1; alu = ALU_ADD; is_pop = 1'b1; end
         6'h02: is_jump = 1'b1;
         6'h03: begin is_jump = 1'b1; is_jal = 1'b1; end
         default: ;
      endcase
      ex_bits[25:21] = alu;
   end

   // EXE selects are held through MEM and WB so ZERO/alu_out stay stable.
   always_comb begin
      ctrl  = '0;
      read  = 1'b0;
      write = 1'b0;
      case (state)
         FETCH: begin
            ctrl[31] = 1'b1;
            ctrl[4]  = 1'b1;
            read     = 1'b1;
         end
         DECODE: begin
            ctrl[7]  = 1'b1;
            ctrl[30] = 1'b1;
            ctrl[27] = 1'b1;
            ctrl[6]  = is_push;
         end
         EXE: ctrl = ex_bits;
         MEM: begin
            ctrl = ex_bits;
            if (is_lw || is_pop) begin
               ctrl[4] = 1'b1;
               read    = 1'b1;
            end
            if (is_sw || is_push) begin
               ctrl[5]  = 1'b1;
               ctrl[28] = 1'b1;
               write    = 1'b1;
            end
            if (is_push) begin
               ctrl[26] = 1'b1;
               ctrl[29] = 1'b1;
            end
         end
         WB: begin
            ctrl = ex_bits;
            if (is_lw || is_pop) begin
               ctrl[4] = 1'b1;
               read    = 1'b1;
            end
            ctrl[0] = 1'b1;
            ctrl[1] = 1'b1;
            ctrl[3] = 1'b1;
            if (is_beq) ctrl[2] = bus.ZERO;
            if (is_bne) ctrl[2] = ~bus.ZERO;
            if (is_jr) begin
               ctrl[1] = 1'b0;
               ctrl[2] = 1'b0;
            end
            if (is_jump) ctrl[3] = 1'b0;
            if (wr_rd || wr_rt || is_pop) begin
               ctrl[8]  = 1'b1;
               ctrl[14] = 1'b1;
            end
            if (wr_rd || wr_rt) ctrl[11] = 1'b1;
            if (wr_rt) ctrl[9] = 1'b1;
            if (is_lw || is_pop) ctrl[12] = 1'b1;
            if (is_lui) ctrl[13] = 1'b1;
            if (is_jal) begin
               ctrl[8]  = 1'b1;
               ctrl[10] = 1'b1;
            end
            if (is_push || is_pop) ctrl[15] = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.CTRL      = ctrl;
   assign bus.READ      = read;
   assign bus.WRITE     = write;
   assign bus.fsm_state = state;
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: the driver queues the expected per-cycle
// {state, READ, WRITE, CTRL}; a negedge monitor pops and compares.
module tb_control_unit;
   localparam int W = 37;

   logic clk;
   logic rst;
   control_unit_if bus ();

   control_unit dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           check_cnt = 0;
   int           pass_cnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", pass_cnt, check_cnt);
      $fatal(1, "watchdog");
   end

   task automatic expect_cyc(input string nm, input logic [2:0] st, input logic [1:0] rw,
                             input logic [31:0] c);
      exp_q.push_back({st, rw, c});
      name_q.push_back(nm);
   endtask

   // One instruction, starting just after the edge that entered FETCH.
   task automatic run_instr(input string nm, input logic [31:0] ins, input logic z,
                            input logic [31:0] c_dec, input logic [31:0] c_exe,
                            input logic [31:0] c_mem, input logic [1:0] rw_mem,
                            input logic [31:0] c_wb, input logic [1:0] rw_wb);
      bus.INSTRUCTION = ins;
      bus.ZERO        = z;
      expect_cyc({nm, "/fetch"}, 3'd0, 2'b10, 32'h8000_0010);
      @(posedge clk); #1;
      bus.INSTRUCTION = $urandom();
      expect_cyc({nm, "/decode"}, 3'd1, 2'b00, c_dec);
      @(posedge clk); #1;
      expect_cyc({nm, "/exe"}, 3'd2, 2'b00, c_exe);
      @(posedge clk); #1;
      expect_cyc({nm, "/mem"}, 3'd3, rw_mem, c_mem);
      @(posedge clk); #1;
      expect_cyc({nm, "/wb"}, 3'd4, rw_wb, c_wb);
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      logic [W-1:0] exp_v, act_v;
      string        nm;
      if (exp_q.size() != 0) begin
         exp_v = exp_q.pop_front();
         nm    = name_q.pop_front();
         act_v = {bus.fsm_state, bus.READ, bus.WRITE, bus.CTRL};
         check_cnt++;
         if (act_v === exp_v) pass_cnt++;
         else $display("FAIL %s: got state=%0d read=%b write=%b ctrl=%h, expected state=%0d read=%b write=%b ctrl=%h",
                       nm, act_v[36:34], act_v[33], act_v[32], act_v[31:0],
                       exp_v[36:34], exp_v[33], exp_v[32], exp_v[31:0]);
      end
   end

   initial begin
      rst             = 1'b0;
      bus.INSTRUCTION = '0;
      bus.ZERO        = 1'b0;
      @(posedge clk); #1;
      expect_cyc("reset_state", 3'd0, 2'b10, 32'h8000_0010);
      @(posedge clk); #1;
      rst = 1'b1;

      // add interrupted by reset in the middle of EXE
      bus.INSTRUCTION = 32'h0022_1820;
      expect_cyc("pre_rst/fetch", 3'd0, 2'b10, 32'h8000_0010);
      @(posedge clk); #1;
      expect_cyc("pre_rst/decode", 3'd1, 2'b00, 32'h4800_0080);
      @(posedge clk); #1;
      #2 rst = 1'b0;
      expect_cyc("rst_mid_exe", 3'd0, 2'b10, 32'h8000_0010);
      @(posedge clk); #1;
      rst = 1'b1;

      run_instr("add", 32'h0022_1820, 1'b0, 32'h4800_0080, 32'h0030_0000,
                32'h0030_0000, 2'b00, 32'h0030_490B, 2'b00);
      run_instr("beq_z1", 32'h1022_0003, 1'b1, 32'h4800_0080, 32'h0050_0000,
                32'h0050_0000, 2'b00, 32'h0050_000F, 2'b00);
      run_instr("beq_z0", 32'h1022_0003, 1'b0, 32'h4800_0080, 32'h0050_0000,
                32'h0050_0000, 2'b00, 32'h0050_000B, 2'b00);
      run_instr("sw", 32'hAC22_0004, 1'b0, 32'h4800_0080, 32'h0024_0000,
                32'h1024_0020, 2'b01, 32'h0024_000B, 2'b00);
      run_instr("lw", 32'h8C22_0004, 1'b0, 32'h4800_0080, 32'h0024_0000,
                32'h0024_0010, 2'b10, 32'h0024_5B1B, 2'b10);
      run_instr("push", 32'h6C00_0000, 1'b0, 32'h4800_00C0, 32'h0049_0000,
                32'h3449_0020, 2'b01, 32'h0049_800B, 2'b00);
      run_instr("pop", 32'h7000_0000, 1'b0, 32'h4800_0080, 32'h0029_0000,
                32'h0029_0010, 2'b10, 32'h0029_D11B, 2'b10);
      run_instr("sll", 32'h0001_1041, 1'b0, 32'h4800_0080, 32'h00AA_0000,
                32'h00AA_0000, 2'b00, 32'h00AA_490B, 2'b00);
      run_instr("jr", 32'h03E0_0008, 1'b0, 32'h4800_0080, 32'h0000_0000,
                32'h0000_0000, 2'b00, 32'h0000_0009, 2'b00);
      run_instr("jal", 32'h0C00_0040, 1'b0, 32'h4800_0080, 32'h0000_0000,
                32'h0000_0000, 2'b00, 32'h0000_0503, 2'b00);
      run_instr("bad_op", 32'hFC00_0000, 1'b1, 32'h4800_0080, 32'h0000_0000,
                32'h0000_0000, 2'b00, 32'h0000_000B, 2'b00);

      @(negedge clk); #1;
      check_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL drain: got %0d entries left in queue, expected 0", exp_q.size());

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
